// File: rtl/iddmm_pkg.sv
// Shared definitions for the Montgomery result reader: FSM states,
// default geometry and the cal_sign select encoding.
package iddmm_pkg;

  localparam int K_DEF      = 128;
  localparam int N_DEF      = 32;
  localparam int ADDR_W_DEF = $clog2(N_DEF);

  // cal_sign = 1 means (a - p) went negative, so the raw a is already reduced.
  localparam logic SEL_A   = 1'b1;
  localparam logic SEL_SUB = 1'b0;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    PREFETCH = 2'd1,
    STREAM   = 2'd2
  } state_e;

endpackage

// File: rtl/iddmm_res_buf.sv
// N x K simple dual-port result buffer: one write port, one registered
// read port with 1-cycle latency. The read register holds its value when
// no read is issued, which the reader relies on for output stability.
module iddmm_res_buf #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [K-1:0]      wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [K-1:0]      rdata_o
);

  logic [K-1:0] mem [N];
  logic [K-1:0] rdata_q;

  // Write port: store one word per strobe.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read port: registered, updates only when a read is issued.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iddmm_result_reader.sv
// Consumer of the Montgomery core's result writes. Buffers the raw (a) and
// subtracted (a - p) word streams, latches the final-compare sign, then
// streams the reduced result LSW-first over valid/ready at 1 word/cycle.
module iddmm_result_reader
  import iddmm_pkg::*;
#(
  parameter int K      = K_DEF,
  parameter int N      = N_DEF,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_wr_en_a,
  input  logic [K-1:0]      fifo_wr_data_a,
  input  logic              fifo_wr_en_sub,
  input  logic [K-1:0]      fifo_wr_data_sub,
  input  logic              cal_done,
  input  logic              cal_sign,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [K-1:0]      o_data,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_last,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N-1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_a_q, cnt_a_d;
  logic [ADDR_W:0]     cnt_sub_q, cnt_sub_d;
  logic                sel_q, sel_d;
  logic                sel_valid_q, sel_valid_d;
  logic                err_q, err_d;
  logic                vld_q, vld_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;

  logic                collecting;
  logic                we_a, we_sub;
  logic                hs, last_hs;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [K-1:0]        rdata_a, rdata_sub;

  assign collecting = (state_q == COLLECT);
  assign we_a       = collecting & fifo_wr_en_a   & (cnt_a_q   != CNT_FULL);
  assign we_sub     = collecting & fifo_wr_en_sub & (cnt_sub_q != CNT_FULL);

  assign hs      = vld_q & o_ready;
  assign last_hs = hs & (idx_q == IDX_LAST);

  // Read-ahead: the word after a handshake is fetched in the handshake
  // cycle itself, so it lands in the read register with no bubble. With no
  // handshake the read register holds, keeping o_data stable.
  assign rd_en   = (state_q == PREFETCH) | (hs & ~last_hs);
  assign rd_addr = (state_q == PREFETCH) ? '0 : idx_q + 1'b1;

  iddmm_res_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_buf_a (
    .clk     (clk),
    .we_i    (we_a),
    .waddr_i (cnt_a_q[ADDR_W-1:0]),
    .wdata_i (fifo_wr_data_a),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rdata_a)
  );

  iddmm_res_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_buf_sub (
    .clk     (clk),
    .we_i    (we_sub),
    .waddr_i (cnt_sub_q[ADDR_W-1:0]),
    .wdata_i (fifo_wr_data_sub),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rdata_sub)
  );

  // Next-state: collection bookkeeping, prefetch, streaming and error capture.
  always_comb begin
    state_d     = state_q;
    cnt_a_d     = cnt_a_q;
    cnt_sub_d   = cnt_sub_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    err_d       = err_q;
    vld_d       = vld_q;
    idx_d       = idx_q;

    case (state_q)
      COLLECT: begin
        if (fifo_wr_en_a) begin
          if (cnt_a_q == CNT_FULL) err_d = 1'b1;
          else                     cnt_a_d = cnt_a_q + 1'b1;
        end
        if (fifo_wr_en_sub) begin
          if (cnt_sub_q == CNT_FULL) err_d = 1'b1;
          else                       cnt_sub_d = cnt_sub_q + 1'b1;
        end
        if (cal_done) begin
          if (sel_valid_q) begin
            err_d = 1'b1;          // first sign wins
          end else begin
            sel_d       = cal_sign;
            sel_valid_d = 1'b1;
          end
        end
        // Decide on next-state values so a same-cycle final event still
        // leaves COLLECT on the very next edge.
        if (sel_valid_d && (cnt_a_d == CNT_FULL) && (cnt_sub_d == CNT_FULL))
          state_d = PREFETCH;
      end
      PREFETCH: begin
        state_d = STREAM;
        vld_d   = 1'b1;
        idx_d   = '0;
      end
      STREAM: begin
        if (last_hs) begin
          state_d     = COLLECT;
          vld_d       = 1'b0;
          idx_d       = '0;
          cnt_a_d     = '0;
          cnt_sub_d   = '0;
          sel_valid_d = 1'b0;
        end else if (hs) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Upstream must wait for busy=0; anything arriving early is dropped.
    if (!collecting && (fifo_wr_en_a || fifo_wr_en_sub || cal_done))
      err_d = 1'b1;
  end

  // State registers with synchronous reset; buffer contents are simply
  // abandoned on reset since the counts return to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_a_q     <= '0;
      cnt_sub_q   <= '0;
      sel_q       <= SEL_SUB;
      sel_valid_q <= 1'b0;
      err_q       <= 1'b0;
      vld_q       <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_a_q     <= cnt_a_d;
      cnt_sub_q   <= cnt_sub_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      err_q       <= err_d;
      vld_q       <= vld_d;
      idx_q       <= idx_d;
    end
  end

  // The read registers are not reset, so o_data is forced to zero when idle.
  assign o_valid = vld_q;
  assign o_data  = vld_q ? ((sel_q == SEL_A) ? rdata_a : rdata_sub) : '0;
  assign o_idx   = idx_q;
  assign o_last  = vld_q & (idx_q == IDX_LAST);
  assign busy    = ~collecting | (cnt_a_q != '0) | (cnt_sub_q != '0) | sel_valid_q;
  assign err     = err_q;

endmodule
